// File: rtl/arm_seq_ctrl.sv
// rtl/arm_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for the ARM datapath
//
// Purpose: fetches one instruction at a time over a req/ready instruction
// port into the IR feeding arm_decode, steps it through EXEC/MEM/WB and
// gates the decoder write enables so register_file, PC and CPSR are only
// written in the right cycle and only when the condition check passes.
//
// Ports:
//   clk, rst_b                  clock (rising edge), async active-low reset
//   imem_req/imem_ready         instruction fetch handshake, address = pc_out
//   imem_rdata                  fetched instruction
//   ir                          latched instruction for arm_decode
//   cond_pass                   condition-check result for ir
//   dec_rd_we/pc_we/cpsr_we     raw decoder write enables
//   rf_rd_we/rf_pc_we/cpsr_we   gated single-cycle write enables
//   pc_inc                      PC <= PC+4 strobe, fires with the fetch handshake
//   dmem_req/dmem_we/dmem_ready data access handshake (dmem_we=1 for stores)
//   retire, undef               one-cycle completion / undefined-class pulses
//   bus_err                     sticky memory-timeout flag
//   retired_cnt                 wrapping count of retire pulses
//   state_dbg                   current state encoding
module arm_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic             cond_pass,
  input  logic             dec_rd_we,
  input  logic             dec_pc_we,
  input  logic             dec_cpsr_we,
  output logic             rf_rd_we,
  output logic             rf_pc_we,
  output logic             rf_cpsr_we,
  output logic             pc_inc,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             retire,
  output logic             undef,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       waiting;
  logic       retire_q;
  logic       mem_go;      // load/store that passed its condition
  logic       store_done;
  logic       is_dp;
  logic       is_ls;
  logic       is_br;
  logic       fetch_undef;

  assign is_dp       = (ir[27:26] == 2'b00);
  assign is_ls       = (ir[27:26] == 2'b01);
  assign is_br       = (ir[27:25] == 3'b101);
  assign fetch_undef = !((imem_rdata[27:26] == 2'b00) || (imem_rdata[27:26] == 2'b01) ||
                         (imem_rdata[27:25] == 3'b101));

  // Only cycles spent actually requesting without a response count as waits.
  assign waiting  = ((state == S_FETCH) && !imem_ready) || (dmem_req && !dmem_ready);
  assign wait_nxt = wait_cnt + 8'd1;

  // The fetch request and its PC increment complete in the handshake cycle
  // itself; both are held low while reset is asserted.
  assign imem_req   = rst_b && (state == S_FETCH);
  assign pc_inc     = imem_req && imem_ready;
  // A store retires in the cycle its data access completes.
  assign store_done = dmem_req && dmem_we && dmem_ready;
  assign retire     = retire_q || store_done;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= S_FETCH;
      ir          <= 32'h0;
      wait_cnt    <= 8'd0;
      retire_q    <= 1'b0;
      undef       <= 1'b0;
      rf_rd_we    <= 1'b0;
      rf_pc_we    <= 1'b0;
      rf_cpsr_we  <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      mem_go      <= 1'b0;
      bus_err     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      retire_q   <= 1'b0;
      undef      <= 1'b0;
      rf_rd_we   <= 1'b0;
      rf_pc_we   <= 1'b0;
      rf_cpsr_we <= 1'b0;
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (waiting) wait_cnt <= wait_nxt;

      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            wait_cnt <= 8'd0;
            state    <= S_DECODE;
            // Undefined classes are known at latch time so their pulses can
            // be registered for the DECODE cycle.
            if (fetch_undef) begin
              undef    <= 1'b1;
              retire_q <= 1'b1;
            end
          end else if (wait_nxt == TIMEOUT) begin
            wait_cnt <= 8'd0;
            state    <= S_ABORT;
          end
        end

        S_DECODE: begin
          if (undef) begin
            state <= S_FETCH;
          end else begin
            // Decoder and condition outputs have settled by the end of
            // DECODE; the EXEC enables are captured here as clean pulses.
            state    <= S_EXEC;
            mem_go   <= is_ls && cond_pass;
            retire_q <= !(is_ls && cond_pass);
            if (cond_pass && is_dp) begin
              rf_rd_we   <= dec_rd_we;
              rf_pc_we   <= dec_pc_we;
              rf_cpsr_we <= dec_cpsr_we;
            end
            if (cond_pass && is_br) begin
              rf_pc_we <= 1'b1;
              rf_rd_we <= dec_rd_we;
            end
          end
        end

        S_EXEC: begin
          if (mem_go) begin
            state    <= S_MEM;
            dmem_req <= 1'b1;
            dmem_we  <= ~ir[20];
          end else begin
            state <= S_FETCH;
          end
        end

        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= 8'd0;
            if (ir[20]) begin
              state    <= S_WB;
              retire_q <= 1'b1;
              if (ir[15:12] == 4'hF) rf_pc_we <= 1'b1;
              else                   rf_rd_we <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else if (wait_nxt == TIMEOUT) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= S_ABORT;
          end
        end

        S_WB: state <= S_FETCH;

        S_ABORT: begin
          bus_err <= 1'b1;
          state   <= S_FETCH;
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// tb/tb_arm_seq_ctrl.sv - self-checking bench for arm_seq_ctrl
module tb_arm_seq_ctrl;
  localparam int TMO = 15;
  localparam int CW  = 4;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, A = 3'd5;

  logic          clk, rst_b;
  logic          imem_req, imem_ready;
  logic [31:0]   imem_rdata, ir;
  logic          cond_pass, dec_rd_we, dec_pc_we, dec_cpsr_we;
  logic          rf_rd_we, rf_pc_we, rf_cpsr_we, pc_inc;
  logic          dmem_req, dmem_we, dmem_ready;
  logic          retire, undef, bus_err;
  logic [CW-1:0] retired_cnt;
  logic [2:0]    state_dbg;

  arm_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .cond_pass(cond_pass),
    .dec_rd_we(dec_rd_we), .dec_pc_we(dec_pc_we), .dec_cpsr_we(dec_cpsr_we),
    .rf_rd_we(rf_rd_we), .rf_pc_we(rf_pc_we), .rf_cpsr_we(rf_cpsr_we),
    .pc_inc(pc_inc), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .retire(retire), .undef(undef), .bus_err(bus_err),
    .retired_cnt(retired_cnt), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, pinc, rd, pc, cpsr, dreq, dwe, ret, und;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  logic stim_ir[$];
  logic stim_dr[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One expected cycle plus the ready inputs to drive during it.
  function automatic void add(input logic [2:0] st, input logic ireq, pinc, rd, pc, cpsr,
                              dreq, dwe, ret, und, input logic [31:0] inst,
                              input logic rdy_i, rdy_d);
    exp_t e;
    e.st = st; e.ireq = ireq; e.pinc = pinc; e.rd = rd; e.pc = pc; e.cpsr = cpsr;
    e.dreq = dreq; e.dwe = dwe; e.ret = ret; e.und = und; e.inst = inst;
    exp_q.push_back(e);
    stim_ir.push_back(rdy_i);
    stim_dr.push_back(rdy_d);
  endfunction

  // Plays the queued stimulus; reports the 1-based cycle of the retire pulse
  // and how often pc_inc / dmem_req were seen high.
  task automatic drive(output int rc, output int pci, output int drq);
    rc = 0; pci = 0; drq = 0;
    for (int i = 0; i < stim_ir.size(); i++) begin
      imem_ready = stim_ir[i];
      dmem_ready = stim_dr[i];
      #1;
      if (retire)   rc = i + 1;
      if (pc_inc)   pci++;
      if (dmem_req) drq++;
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    stim_ir.delete();
    stim_dr.delete();
  endtask

  // Instruction-level model: expands one instruction into its cycle trace.
  task automatic run(input logic [31:0] inst, input logic cp, drd, dpc, dcpsr,
                     input int fw, input int mw, input logic nz,
                     output int rc, output int pci, output int drq);
    logic dp, ls, br, ld;
    dp = (inst[27:25] == 3'd0) || (inst[27:25] == 3'd1);
    ls = (inst[27:25] == 3'd2) || (inst[27:25] == 3'd3);
    br = (inst[27:25] == 3'd5);
    ld = inst[20];
    imem_rdata = inst; cond_pass = cp; dec_rd_we = drd; dec_pc_we = dpc; dec_cpsr_we = dcpsr;
    for (int i = 0; i < ((fw < TMO) ? fw : TMO); i++)
      add(F, 1, 0, 0, 0, 0, 0, 0, 0, 0, inst, 0, nz);
    if (fw >= TMO) begin
      add(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, inst, nz, nz);
    end else begin
      add(F, 1, 1, 0, 0, 0, 0, 0, 0, 0, inst, 1, nz);
      if (!(dp || ls || br)) begin
        add(D, 0, 0, 0, 0, 0, 0, 0, 1, 1, inst, nz, nz);
      end else begin
        add(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, inst, nz, nz);
        if (!(ls && cp)) begin
          add(E, 0, 0, cp && drd, cp && (br || dpc), cp && dp && dcpsr, 0, 0, 1, 0, inst, nz, nz);
        end else begin
          add(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, inst, nz, nz);
          for (int i = 0; i < ((mw < TMO) ? mw : TMO); i++)
            add(M, 0, 0, 0, 0, 0, 1, !ld, 0, 0, inst, nz, 0);
          if (mw >= TMO) begin
            add(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, inst, nz, nz);
          end else begin
            add(M, 0, 0, 0, 0, 0, 1, !ld, !ld, 0, inst, nz, 1);
            if (ld)
              add(W, 0, 0, inst[15:12] != 4'hF, inst[15:12] == 4'hF, 0, 0, 0, 1, 0, inst, nz, nz);
          end
        end
      end
    end
    drive(rc, pci, drq);
  endtask

  // Compare process: every traced cycle is checked against the model.
  initial begin : cmp
    exp_t          e;
    logic [CW-1:0] m_cnt;
    logic          m_berr;
    logic [31:0]   m_ir;
    m_cnt = '0; m_berr = 1'b0; m_ir = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        m_cnt = '0; m_berr = 1'b0; m_ir = '0;
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state_dbg",   32'(state_dbg),   32'(e.st));
        chk("imem_req",    32'(imem_req),    32'(e.ireq));
        chk("pc_inc",      32'(pc_inc),      32'(e.pinc));
        chk("rf_rd_we",    32'(rf_rd_we),    32'(e.rd));
        chk("rf_pc_we",    32'(rf_pc_we),    32'(e.pc));
        chk("rf_cpsr_we",  32'(rf_cpsr_we),  32'(e.cpsr));
        chk("dmem_req",    32'(dmem_req),    32'(e.dreq));
        chk("dmem_we",     32'(dmem_we),     32'(e.dwe));
        chk("retire",      32'(retire),      32'(e.ret));
        chk("undef",       32'(undef),       32'(e.und));
        chk("bus_err",     32'(bus_err),     32'(m_berr));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        chk("ir",          ir,               m_ir);
        if (e.pinc)    m_ir   = e.inst;
        if (e.ret)     m_cnt  = m_cnt + CW'(1);
        if (e.st == A) m_berr = 1'b1;
      end
    end
  end

  initial begin : main
    int rc, pci, drq;
    rst_b = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; imem_rdata = 32'h0;
    cond_pass = 1'b1; dec_rd_we = 1'b1; dec_pc_we = 1'b1; dec_cpsr_we = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state",    32'(state_dbg),   32'd0);
    chk("rst_ir",       ir,               32'h0);
    chk("rst_cnt",      32'(retired_cnt), 32'd0);
    chk("rst_bus_err",  32'(bus_err),     32'd0);
    chk("rst_imem_req", 32'(imem_req),    32'd0);
    chk("rst_pc_inc",   32'(pc_inc),      32'd0);
    chk("rst_rf_rd_we", 32'(rf_rd_we),    32'd0);
    chk("rst_retire",   32'(retire),      32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;

    run(32'hE0834002, 1, 1, 0, 0, 0, 0, 0, rc, pci, drq);       // ADD
    chk("add_retire_cycle", 32'(rc), 32'd3);
    chk("add_ir", ir, 32'hE0834002);
    chk("add_cnt", 32'(retired_cnt), 32'd1);
    run(32'hE1570008, 1, 0, 0, 1, 0, 0, 0, rc, pci, drq);       // CMP
    chk("cmp_retire_cycle", 32'(rc), 32'd3);
    run(32'hE1570008, 0, 0, 0, 1, 0, 0, 0, rc, pci, drq);       // CMP, cond fail
    chk("cmp_fail_retire_cycle", 32'(rc), 32'd3);
    run(32'hEB00000A, 1, 1, 0, 0, 0, 0, 0, rc, pci, drq);       // BL
    chk("bl_retire_cycle", 32'(rc), 32'd3);
    chk("bl_pc_inc_count", 32'(pci), 32'd1);
    run(32'hE5912000, 1, 1, 0, 0, 0, 3, 0, rc, pci, drq);       // LDR, 3 waits
    chk("ldr_retire_cycle", 32'(rc), 32'd8);
    chk("ldr_dmem_req_cycles", 32'(drq), 32'd4);
    run(32'hE5812000, 1, 0, 0, 0, 0, 3, 0, rc, pci, drq);       // STR, 3 waits
    chk("str_retire_cycle", 32'(rc), 32'd7);
    run(32'hE591F000, 1, 1, 0, 0, 0, 0, 0, rc, pci, drq);       // LDR PC
    chk("ldr_pc_retire_cycle", 32'(rc), 32'd5);
    run(32'hE0834002, 1, 1, 0, 0, 2, 0, 1, rc, pci, drq);       // stray readies
    chk("add_noise_retire_cycle", 32'(rc), 32'd5);
    run(32'hE5912000, 0, 1, 0, 0, 0, 3, 0, rc, pci, drq);       // LDR, cond fail
    chk("ldr_fail_retire_cycle", 32'(rc), 32'd3);
    chk("ldr_fail_dmem_req", 32'(drq), 32'd0);
    run(32'hE0834002, 1, 1, 0, 0, TMO, 0, 0, rc, pci, drq);     // fetch timeout
    chk("fetch_tmo_no_retire", 32'(rc), 32'd0);
    chk("fetch_tmo_bus_err", 32'(bus_err), 32'd1);
    run(32'hE0834002, 1, 1, 0, 0, 0, 0, 0, rc, pci, drq);       // refetch
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    run(32'hE5912000, 1, 1, 0, 0, 0, 40, 0, rc, pci, drq);      // data timeout
    chk("mem_tmo_dmem_req_cycles", 32'(drq), 32'd15);
    chk("mem_tmo_no_retire", 32'(rc), 32'd0);

    // Reset while waiting in MEM.
    imem_rdata = 32'hE5912000; cond_pass = 1'b1; dec_rd_we = 1'b1;
    add(F, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hE5912000, 1, 0);
    add(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hE5912000, 0, 0);
    add(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hE5912000, 0, 0);
    add(M, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hE5912000, 0, 0);
    add(M, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hE5912000, 0, 0);
    drive(rc, pci, drq);
    #1 rst_b = 1'b0;
    #1;
    chk("midrst_state",    32'(state_dbg),   32'd0);
    chk("midrst_bus_err",  32'(bus_err),     32'd0);
    chk("midrst_dmem_req", 32'(dmem_req),    32'd0);
    chk("midrst_rf_rd_we", 32'(rf_rd_we),    32'd0);
    chk("midrst_rf_pc_we", 32'(rf_pc_we),    32'd0);
    chk("midrst_cnt",      32'(retired_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    run(32'hEC000000, 1, 1, 1, 1, 0, 0, 0, rc, pci, drq);       // undefined class
    chk("undef_retire_cycle", 32'(rc), 32'd2);
    for (int i = 1; i < 15; i++) run(32'hEC000000, 1, 1, 1, 1, 0, 0, 0, rc, pci, drq);
    chk("cnt_at_15", 32'(retired_cnt), 32'd15);
    run(32'hEC000000, 1, 1, 1, 1, 0, 0, 0, rc, pci, drq);
    chk("cnt_wrap", 32'(retired_cnt), 32'd0);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
